ram_4k_loader: RTL and testbench

RAM_4K_LOADER -- requirements
Module: ram_4k_loader

---
 rtl/ram_4k_loader_if.sv | 10 +
 rtl/ram_4k_loader.sv | 127 ++++++++++++
 tb/tb_ram_4k_loader.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_4k_loader_if.sv
// rtl/ram_4k_loader_if.sv - stream word channel feeding the 4K RAM loader
interface ram_4k_loader_if;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;

  modport master (output s_data, s_valid, s_last, input s_ready);
  modport slave  (input s_data, s_valid, s_last, output s_ready);
endinterface

// File: rtl/ram_4k_loader.sv
// rtl/ram_4k_loader.sv - streams words into a 4K x 16 RAM, CPU passthrough when idle
// Optional pre-load zero fill of the whole RAM is enabled by RAM_LOADER_CLEAR_EN.
module ram_4k_loader #(
  parameter logic [11:0] BASE_ADDR = 12'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  ram_4k_loader_if.slave s,
  input  logic [15:0] cpu_in,
  input  logic [11:0] cpu_address,
  input  logic        cpu_load,
  output logic [15:0] ram_in,
  output logic [11:0] ram_address,
  output logic        ram_load,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [12:0] word_count
);
  localparam logic [11:0] LAST_ADDR = 12'hFFF;

`ifdef RAM_LOADER_CLEAR_EN
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_LOAD, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;
`endif

  state_t      r_state;
  state_t      w_next;
  logic [11:0] r_ptr;
  logic [12:0] r_count;
  logic        r_done;
  logic        r_ovf;
  logic        w_in_load;
  logic        w_accept;
  logic        w_start;
  logic        w_end;

  // Reset gates the handshake so a word presented in the reset cycle never reaches RAM.
  assign w_in_load = (r_state == S_LOAD) && !reset;
  assign w_accept  = w_in_load && s.s_valid;
  assign w_start   = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
  assign w_end     = w_accept && (s.s_last || (r_ptr == LAST_ADDR));

  assign s.s_ready  = w_in_load;
  assign done       = r_done;
  assign overflow   = r_ovf;
  assign word_count = r_count;

`ifdef RAM_LOADER_CLEAR_EN
  logic [11:0] r_clr_addr;
  logic        w_in_clear;
  assign w_in_clear = (r_state == S_CLEAR) && !reset;
  assign busy       = w_in_load || w_in_clear;
`else
  assign busy       = w_in_load;
`endif

  always_comb begin
    w_next      = r_state;
    ram_in      = cpu_in;
    ram_address = cpu_address;
    ram_load    = cpu_load;
    case (r_state)
      S_IDLE, S_DONE: begin
`ifdef RAM_LOADER_CLEAR_EN
        if (start) w_next = S_CLEAR;
`else
        if (start) w_next = S_LOAD;
`endif
      end
`ifdef RAM_LOADER_CLEAR_EN
      S_CLEAR: begin
        if (!reset) begin
          ram_in      = 16'h0000;
          ram_address = r_clr_addr;
          ram_load    = 1'b1;
        end
        if (r_clr_addr == LAST_ADDR) w_next = S_LOAD;
      end
`endif
      S_LOAD: begin
        if (!reset) begin
          ram_in      = s.s_data;
          ram_address = r_ptr;
          ram_load    = w_accept;
        end
        if (w_end) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ptr   <= BASE_ADDR;
      r_count <= 13'd0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
`ifdef RAM_LOADER_CLEAR_EN
      r_clr_addr <= 12'd0;
`endif
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_ptr   <= BASE_ADDR;
        r_count <= 13'd0;
        r_done  <= 1'b0;
        r_ovf   <= 1'b0;
      end
      // The pointer parks at the top address; the final word there ends the load.
      if (w_accept) begin
        r_count <= r_count + 13'd1;
        if (r_ptr != LAST_ADDR) r_ptr <= r_ptr + 12'd1;
      end
      if (w_end) begin
        r_done <= 1'b1;
        if (!s.s_last) r_ovf <= 1'b1;
      end
`ifdef RAM_LOADER_CLEAR_EN
      r_clr_addr <= (r_state == S_CLEAR) ? r_clr_addr + 12'd1 : 12'd0;
`endif
    end
  end
endmodule

// File: tb/tb_ram_4k_loader.sv
// tb/tb_ram_4k_loader.sv - self-checking bench for ram_4k_loader
// Covers both builds; the zero-fill checks apply when RAM_LOADER_CLEAR_EN is defined.
module tb_ram_4k_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start0, start1;
  logic [15:0] cpu_in;
  logic [11:0] cpu_address;
  logic        cpu_load;

  ram_4k_loader_if sif0 ();
  ram_4k_loader_if sif1 ();

  logic [15:0] ram_in0, ram_in1;
  logic [11:0] ram_address0, ram_address1;
  logic        ram_load0, ram_load1;
  logic        busy0, busy1, done0, done1, overflow0, overflow1;
  logic [12:0] word_count0, word_count1;

  ram_4k_loader #(.BASE_ADDR(12'd0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .s(sif0.slave),
    .cpu_in(cpu_in), .cpu_address(cpu_address), .cpu_load(cpu_load),
    .ram_in(ram_in0), .ram_address(ram_address0), .ram_load(ram_load0),
    .busy(busy0), .done(done0), .overflow(overflow0), .word_count(word_count0)
  );

  ram_4k_loader #(.BASE_ADDR(12'd4094)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .s(sif1.slave),
    .cpu_in(cpu_in), .cpu_address(cpu_address), .cpu_load(cpu_load),
    .ram_in(ram_in1), .ram_address(ram_address1), .ram_load(ram_load1),
    .busy(busy1), .done(done1), .overflow(overflow1), .word_count(word_count1)
  );

  // Downstream 4K RAMs driven by the loaders' RAM ports.
  logic [15:0] mem0 [4096];
  logic [15:0] mem1 [4096];
  always @(posedge clk) begin
    if (ram_load0) mem0[ram_address0] <= ram_in0;
    if (ram_load1) mem1[ram_address1] <= ram_in1;
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc;
  logic [15:0] wq [$];
  logic [15:0] w1a [3];
  logic [15:0] prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start0_go();
    bit ok;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
`ifdef RAM_LOADER_CLEAR_EN
    ok = 1'b1;
    for (int a = 0; a < 4096; a++) begin
      @(negedge clk);
      if (!(busy0 === 1'b1 && sif0.s_ready === 1'b0 && ram_load0 === 1'b1 &&
            ram_address0 === 12'(a) && ram_in0 === 16'h0000)) ok = 1'b0;
      @(posedge clk); #1;
    end
    chk("clear_sequence", 32'(ok), 32'd1);
`else
    ok = 1'b1;
`endif
  endtask

  // Streams wq into dut0 from base 0; expected address of word k is k.
  task automatic load0(input bit use_pat, input logic [31:0] vpat, input int gap_pct);
    int   n;
    int   acc;
    int   c;
    logic v;
    n   = wq.size();
    acc = 0;
    c   = 0;
    start0_go();
    while (acc < n && c < 2000) begin
      v = use_pat ? vpat[c[4:0]] : (int'($urandom_range(99)) >= gap_pct);
      sif0.s_valid = v;
      sif0.s_data  = wq[acc];
      sif0.s_last  = v ? (acc == n - 1) : 1'($urandom_range(1));
      cpu_load     = 1'($urandom_range(1));
      cpu_address  = 12'($urandom);
      cpu_in       = 16'($urandom);
      start0       = 1'($urandom_range(1));
      @(negedge clk);
      chk("load_ready", 32'(sif0.s_ready), 32'd1);
      chk("load_busy", 32'(busy0), 32'd1);
      chk("load_done_cleared", 32'(done0), 32'd0);
      chk("load_count", 32'(word_count0), 32'(acc));
      chk("load_we", 32'(ram_load0), 32'(v));
      chk("load_addr", 32'(ram_address0), 32'(acc));
      chk("load_data", 32'(ram_in0), 32'(wq[acc]));
      @(posedge clk); #1;
      if (v) acc++;
      c++;
    end
    chk("load_timeout", 32'(c < 2000), 32'd1);
    sif0.s_valid = 1'b0;
    sif0.s_last  = 1'b0;
    start0       = 1'b0;
    cpu_load     = 1'b0;
    @(negedge clk);
    chk("end_done", 32'(done0), 32'd1);
    chk("end_overflow", 32'(overflow0), 32'd0);
    chk("end_count", 32'(word_count0), 32'(n));
    chk("end_busy", 32'(busy0), 32'd0);
    chk("end_ready", 32'(sif0.s_ready), 32'd0);
    for (int k = 0; k < n; k++) chk("end_mem", 32'(mem0[k]), 32'(wq[k]));
    @(posedge clk); #1;
  endtask

  task automatic start1_go();
    int c;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    c = 0;
    while (sif1.s_ready !== 1'b1 && c < 5000) begin
      @(posedge clk); #1;
      c++;
    end
    chk("d1_wait_ready", 32'(c < 5000), 32'd1);
  endtask

  initial begin
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
    cpu_in = 16'hA5A5; cpu_address = 12'd5; cpu_load = 1'b1;
    sif0.s_valid = 1'b0; sif0.s_last = 1'b0; sif0.s_data = 16'h0;
    sif1.s_valid = 1'b0; sif1.s_last = 1'b0; sif1.s_data = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_ready", 32'(sif0.s_ready), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_overflow", 32'(overflow0), 32'd0);
    chk("rst_count", 32'(word_count0), 32'd0);
    chk("rst_pass_we", 32'(ram_load0), 32'd1);
    chk("rst_pass_addr", 32'(ram_address0), 32'd5);
    @(posedge clk); #1;
    reset = 1'b0; cpu_load = 1'b0; cpu_address = 12'd7; cpu_in = 16'h1234;
    @(negedge clk);
    chk("idle_pass_addr", 32'(ram_address0), 32'd7);
    chk("idle_pass_data", 32'(ram_in0), 32'h1234);
    chk("idle_pass_we", 32'(ram_load0), 32'd0);
    @(posedge clk); #1;

    wq = '{16'h1111, 16'h2222, 16'h3333};
    load0(1'b1, 32'hFFFF_FFFF, 0);

    cpu_load = 1'b1; cpu_address = 12'd100; cpu_in = 16'hBEEF;
    @(negedge clk);
    chk("done_pass_we", 32'(ram_load0), 32'd1);
    chk("done_pass_addr", 32'(ram_address0), 32'd100);
    chk("done_pass_data", 32'(ram_in0), 32'hBEEF);
    @(posedge clk); #1;
    cpu_load = 1'b0;
    @(negedge clk);
    chk("done_pass_mem", 32'(mem0[100]), 32'hBEEF);
    chk("done_hold", 32'(done0), 32'd1);
    @(posedge clk); #1;

    wq = '{16'($urandom), 16'($urandom)};
    load0(1'b1, 32'h0000_0009, 0);

    repeat (6) begin
      wq.delete();
      repeat ($urandom_range(1, 20)) wq.push_back(16'($urandom));
      load0(1'b0, 32'd0, int'($urandom_range(0, 60)));
    end

    // Overflow at the top of RAM: third word must be refused.
    for (int k = 0; k < 3; k++) w1a[k] = 16'($urandom);
    start1_go();
    for (int k = 0; k < 2; k++) begin
      sif1.s_valid = 1'b1; sif1.s_data = w1a[k]; sif1.s_last = 1'b0;
      @(negedge clk);
      chk("ovf_we", 32'(ram_load1), 32'd1);
      chk("ovf_addr", 32'(ram_address1), 32'(4094 + k));
      @(posedge clk); #1;
    end
    sif1.s_data = w1a[2];
    @(negedge clk);
    chk("ovf_ready_word3", 32'(sif1.s_ready), 32'd0);
    chk("ovf_we_word3", 32'(ram_load1), 32'd0);
    chk("ovf_done", 32'(done1), 32'd1);
    chk("ovf_flag", 32'(overflow1), 32'd1);
    chk("ovf_count", 32'(word_count1), 32'd2);
    chk("ovf_mem4094", 32'(mem1[4094]), 32'(w1a[0]));
    chk("ovf_mem4095", 32'(mem1[4095]), 32'(w1a[1]));
    @(posedge clk); #1;
    sif1.s_valid = 1'b0;

    // Ending exactly at the top with last set is a clean finish.
    start1_go();
    for (int k = 0; k < 2; k++) begin
      sif1.s_valid = 1'b1; sif1.s_data = w1a[2 - k]; sif1.s_last = (k == 1);
      @(posedge clk); #1;
    end
    sif1.s_valid = 1'b0; sif1.s_last = 1'b0;
    @(negedge clk);
    chk("top_last_done", 32'(done1), 32'd1);
    chk("top_last_overflow", 32'(overflow1), 32'd0);
    chk("top_last_count", 32'(word_count1), 32'd2);
    chk("top_last_mem", 32'(mem1[4095]), 32'(w1a[1]));
    @(posedge clk); #1;

    // Reset mid-load after two of five words.
    wq.delete();
    repeat (5) wq.push_back(16'($urandom));
    start0_go();
    for (int k = 0; k < 2; k++) begin
      sif0.s_valid = 1'b1; sif0.s_data = wq[k]; sif0.s_last = 1'b0;
      @(negedge clk);
      chk("rl_addr", 32'(ram_address0), 32'(k));
      @(posedge clk); #1;
    end
    prev = mem0[2];
    sif0.s_data = wq[2]; start0 = 1'b1; reset = 1'b1;
    @(negedge clk);
    chk("rl_during_ready", 32'(sif0.s_ready), 32'd0);
    chk("rl_during_busy", 32'(busy0), 32'd0);
    chk("rl_during_we", 32'(ram_load0), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; start0 = 1'b0; sif0.s_valid = 1'b0;
    @(negedge clk);
    chk("rl_after_busy", 32'(busy0), 32'd0);
    chk("rl_after_ready", 32'(sif0.s_ready), 32'd0);
    chk("rl_after_done", 32'(done0), 32'd0);
    chk("rl_after_count", 32'(word_count0), 32'd0);
    chk("rl_mem_untouched", 32'(mem0[2]), 32'(prev));
    chk("rl_mem_kept", 32'(mem0[1]), 32'(wq[1]));
    @(posedge clk); #1;
    wq = '{16'($urandom), 16'($urandom), 16'($urandom)};
    load0(1'b0, 32'd0, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
